// File: rtl/key_edge_detect_pkg.sv
// Shared widths, switch bit positions and board tie-off values for key_edge_detect.
// Also holds the edge-select helper used by every key lane.
package key_edge_detect_pkg;

    localparam int CNT_W       = 4;
    localparam int SW_W        = 4;

    localparam int SW_EDGE_SEL = 0;
    localparam int SW_BOTH     = 1;
    localparam int SW_HOLD     = 2;
    localparam int SW_CLR      = 3;

    localparam logic [1:0]  DQM_IDLE       = 2'b11;
    localparam logic [12:0] DRAM_ADDR_IDLE = 13'h0000;
    localparam logic [1:0]  DRAM_BA_IDLE   = 2'b00;

    // Both-edges overrides the single-edge select.
    function automatic logic edge_sel(input logic rise, input logic fall,
                                      input logic [SW_W-1:0] sw);
        logic hit;
        if (sw[SW_BOTH])
            hit = rise | fall;
        else if (sw[SW_EDGE_SEL])
            hit = fall;
        else
            hit = rise;
        return hit;
    endfunction

endpackage

// File: rtl/key_edge_unit.sv
// One key lane: synchroniser, optional debounce (KEY_DEBOUNCE_EN), edge detect, wrapping counter.
// Clear beats hold beats count; prev always tracks so releasing hold/clear yields no burst.
module key_edge_unit
    import key_edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             gclk,
    input  logic             grst,
    input  logic             key,
    input  logic [SW_W-1:0]  sw,
    output logic [CNT_W-1:0] cnt
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync;
    logic                   lvl;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    logic                   hit;

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) sync_pipe <= '0;
        else      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], key};
    end

    assign sync = sync_pipe[SYNC_STAGES-1];

`ifdef KEY_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;

    // Accept the new level on the DEBOUNCE_CYCLES-th consecutive clock it differs.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            db_cnt <= '0;
            lvl    <= 1'b0;
        end else if (sync == lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            lvl    <= sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign lvl = sync;
`endif

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;
    assign hit  = edge_sel(rise, fall, sw);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= lvl;
            if (sw[SW_CLR])
                cnt <= '0;
            else if (!sw[SW_HOLD] && hit)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_edge_detect.sv
// DE0-Nano top: two key_edge_unit lanes counting KEY edges onto LED; peripherals tied idle.
// Optional debounce in each lane is enabled by defining KEY_DEBOUNCE_EN.
module key_edge_detect
    import key_edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    output logic [7:0]  LED,
    input  logic [1:0]  KEY,
    input  logic [3:0]  SW,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_CAS_N,
    output logic        DRAM_CKE,
    output logic        DRAM_CLK,
    output logic        DRAM_CS_N,
    inout  wire  [15:0] DRAM_DQ,
    output logic [1:0]  DRAM_DQM,
    output logic        DRAM_RAS_N,
    output logic        DRAM_WE_N,
    output logic        EPCS_ASDO,
    input  logic        EPCS_DATA0,
    output logic        EPCS_DCLK,
    output logic        EPCS_NCSO,
    output logic        G_SENSOR_CS_N,
    input  logic        G_SENSOR_INT,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic        ADC_CS_N,
    output logic        ADC_SADDR,
    output logic        ADC_SCLK,
    input  logic        ADC_SDAT,
    inout  wire  [12:0] GPIO_2,
    input  logic [2:0]  GPIO_2_IN
);

    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
    logic                            unused_inputs;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        key_edge_unit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .gclk (CLOCK_50),
            .grst (RESET),
            .key  (KEY[i]),
            .sw   (SW),
            .cnt  (cnt[i])
        );
    end

    assign LED = {cnt[1], cnt[0]};

    assign DRAM_ADDR     = DRAM_ADDR_IDLE;
    assign DRAM_BA       = DRAM_BA_IDLE;
    assign DRAM_CAS_N    = 1'b1;
    assign DRAM_RAS_N    = 1'b1;
    assign DRAM_WE_N     = 1'b1;
    assign DRAM_CS_N     = 1'b1;
    assign DRAM_CKE      = 1'b0;
    assign DRAM_CLK      = 1'b0;
    assign DRAM_DQM      = DQM_IDLE;
    assign DRAM_DQ       = 16'hzzzz;

    assign EPCS_NCSO     = 1'b1;
    assign EPCS_DCLK     = 1'b0;
    assign EPCS_ASDO     = 1'b0;

    assign G_SENSOR_CS_N = 1'b1;
    assign I2C_SCLK      = 1'b1;
    assign I2C_SDAT      = 1'bz;

    assign ADC_CS_N      = 1'b1;
    assign ADC_SADDR     = 1'b0;
    assign ADC_SCLK      = 1'b0;

    assign GPIO_2        = 13'hzzzz;

    assign unused_inputs = ^{EPCS_DATA0, G_SENSOR_INT, ADC_SDAT, GPIO_2_IN};

endmodule

// File: tb/tb_key_edge_detect.sv
// Directed + random bench for key_edge_detect against a sample-history reference model.
// Inputs change 1ns after a rising edge; LED is checked 1ns after each rising edge.
module tb_key_edge_detect;

    localparam int SYNC_STAGES = 2;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [1:0]  KEY;
    logic [3:0]  SW;
    logic        EPCS_DATA0, G_SENSOR_INT, ADC_SDAT;
    logic [2:0]  GPIO_2_IN;
    wire  [7:0]  LED;
    wire  [12:0] DRAM_ADDR;
    wire  [1:0]  DRAM_BA, DRAM_DQM;
    wire         DRAM_CAS_N, DRAM_CKE, DRAM_CLK, DRAM_CS_N, DRAM_RAS_N, DRAM_WE_N;
    wire  [15:0] DRAM_DQ;
    wire         EPCS_ASDO, EPCS_DCLK, EPCS_NCSO;
    wire         G_SENSOR_CS_N, I2C_SCLK, I2C_SDAT;
    wire         ADC_CS_N, ADC_SADDR, ADC_SCLK;
    wire  [12:0] GPIO_2;

    key_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .LED(LED), .KEY(KEY), .SW(SW),
        .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA), .DRAM_CAS_N(DRAM_CAS_N),
        .DRAM_CKE(DRAM_CKE), .DRAM_CLK(DRAM_CLK), .DRAM_CS_N(DRAM_CS_N),
        .DRAM_DQ(DRAM_DQ), .DRAM_DQM(DRAM_DQM), .DRAM_RAS_N(DRAM_RAS_N),
        .DRAM_WE_N(DRAM_WE_N), .EPCS_ASDO(EPCS_ASDO), .EPCS_DATA0(EPCS_DATA0),
        .EPCS_DCLK(EPCS_DCLK), .EPCS_NCSO(EPCS_NCSO), .G_SENSOR_CS_N(G_SENSOR_CS_N),
        .G_SENSOR_INT(G_SENSOR_INT), .I2C_SCLK(I2C_SCLK), .I2C_SDAT(I2C_SDAT),
        .ADC_CS_N(ADC_CS_N), .ADC_SADDR(ADC_SADDR), .ADC_SCLK(ADC_SCLK),
        .ADC_SDAT(ADC_SDAT), .GPIO_2(GPIO_2), .GPIO_2_IN(GPIO_2_IN)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_err = 0;

    // Model: per key, the last SYNC_STAGES+1 sampled levels; [0] is what prev holds, [1] what sync holds.
    bit          hist[2][$];
    int unsigned mcnt[2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mdl_led();
        logic [3:0] hi, lo;
        hi = 4'(mcnt[1] % 16);
        lo = 4'(mcnt[0] % 16);
        return {hi, lo};
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            hist[k].delete();
            for (int j = 0; j <= SYNC_STAGES; j++) hist[k].push_back(1'b0);
            mcnt[k] = 0;
        end
    endtask

    task automatic tick();
        bit old_l, cur_l, rise, fall, sel;
        @(posedge CLOCK_50);
        if (!RESET) begin
            for (int k = 0; k < 2; k++) begin
                old_l = hist[k][0];
                cur_l = hist[k][1];
                void'(hist[k].pop_front());
                hist[k].push_back(KEY[k]);
                rise = cur_l && !old_l;
                fall = !cur_l && old_l;
                sel  = SW[1] ? (rise || fall) : (SW[0] ? fall : rise);
                if (SW[3])            mcnt[k] = 0;
                else if (!SW[2] && sel) mcnt[k] = (mcnt[k] + 1) % 16;
            end
        end
        #1;
        chk("led_model", {8'h00, LED}, {8'h00, mdl_led()});
    endtask

    task automatic pulse(input int idx, input int hi_t, input int lo_t);
        KEY[idx] = 1'b1;
        repeat (hi_t) tick();
        KEY[idx] = 1'b0;
        repeat (lo_t) tick();
    endtask

    initial begin
        RESET = 1'b1;
        KEY = 2'($urandom);
        SW  = 4'($urandom);
        EPCS_DATA0 = 1'b0; G_SENSOR_INT = 1'b0; ADC_SDAT = 1'b0; GPIO_2_IN = 3'b000;
        mreset();
        #1;
        chk("reset_led",   {8'h00, LED}, 16'h0000);
        chk("dram_cs_n",   {15'h0, DRAM_CS_N}, 16'h0001);
        chk("dram_dqm",    {14'h0, DRAM_DQM}, 16'h0003);
        chk("dram_cke",    {15'h0, DRAM_CKE}, 16'h0000);
        chk("adc_cs_n",    {15'h0, ADC_CS_N}, 16'h0001);
        chk("i2c_sclk",    {15'h0, I2C_SCLK}, 16'h0001);
        chk("epcs_ncso",   {15'h0, EPCS_NCSO}, 16'h0001);
        #2;
        RESET = 1'b0; KEY = 2'b00; SW = 4'b0000;
        repeat (3) tick();
        chk("idle", {8'h00, LED}, 16'h0000);

        // Rise on KEY[0]: visible after the third edge, fall ignored.
        KEY = 2'b01;
        repeat (2) tick();
        chk("rise_lat2", {8'h00, LED}, 16'h0000);
        tick();
        chk("rise_lat3", {8'h00, LED}, 16'h0001);
        repeat (97) tick();
        KEY = 2'b00;
        repeat (5) tick();
        chk("after_fall", {8'h00, LED}, 16'h0001);

        // Fall-only on KEY[1].
        SW = 4'b1000; tick();
        chk("clear1", {8'h00, LED}, 16'h0000);
        SW = 4'b0001; KEY = 2'b10;
        repeat (150) tick();
        chk("fall_pulse", {8'h00, LED}, 16'h0000);
        KEY = 2'b00;
        repeat (2) tick();
        chk("fall_lat2", {8'h00, LED}, 16'h0000);
        tick();
        chk("fall_lat3", {8'h00, LED}, 16'h0010);

        // Both edges, then wrap.
        SW = 4'b1000; tick();
        SW = 4'b0010;
        pulse(0, 4, 4);
        chk("both_one", {12'h000, LED[3:0]}, 16'h0002);
        repeat (7) pulse(0, 4, 4);
        chk("both_wrap", {12'h000, LED[3:0]}, 16'h0000);

        // Hold, release, clear.
        SW = 4'b1000; tick();
        SW = 4'b0000;
        pulse(0, 4, 4);
        chk("pre_hold", {8'h00, LED}, 16'h0001);
        SW = 4'b0100;
        repeat (3) pulse(0, 4, 4);
        chk("hold", {8'h00, LED}, 16'h0001);
        SW = 4'b0000;
        repeat (5) tick();
        chk("hold_release", {8'h00, LED}, 16'h0001);
        SW = 4'b1000; tick();
        SW = 4'b0000;
        chk("clear2", {8'h00, LED}, 16'h0000);

        // Build 0x35, then asynchronous reset with KEY[0] held across release.
        for (int i = 0; i < 5; i++) begin
            KEY = {(i < 3) ? 1'b1 : 1'b0, 1'b1};
            repeat (4) tick();
            KEY = 2'b00;
            repeat (4) tick();
        end
        chk("preset_35", {8'h00, LED}, 16'h0035);
        KEY = 2'b01;
        tick();
        #3 RESET = 1'b1;
        mreset();
        #1;
        chk("async_reset", {8'h00, LED}, 16'h0000);
        RESET = 1'b0;
        repeat (2) tick();
        chk("post_rst_lat2", {8'h00, LED}, 16'h0000);
        tick();
        chk("post_rst_rise", {8'h00, LED}, 16'h0001);

        // Random phase.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 99) < 20) KEY[k] = ~KEY[k];
            if (n % 16 == 0) begin
                SW[1:0] = 2'($urandom);
                SW[2]   = ($urandom_range(0, 9) == 0);
                SW[3]   = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 RESET = 1'b1;
                mreset();
                #1;
                chk("rand_async_reset", {8'h00, LED}, 16'h0000);
                #1 RESET = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
